fetch_unit: RTL and testbench

// Instruction-fetch stage sitting directly upstream of the 16-bit instruction register.
// It holds the PC, issues word reads over a req/ack memory handshake and captures the returned word.
// It drives the IR's data input and load strobe, so the IR receives exactly one write per fetched

---
 rtl/xiphos_pkg.sv | 14 +
 rtl/fetch_timeout_ctr.sv | 40 ++++
 rtl/fetch_unit.sv | 134 +++++++++++++
 tb/tb_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/xiphos_pkg.sv
// Shared types and widths for the xiphos front end.
package xiphos_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        LOAD  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Counts REQ cycles without an ack; flags the cycle whose increment reaches TIMEOUT.
module fetch_timeout_ctr #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    input  logic inc_i,
    output logic expired_o
);

    localparam logic [7:0] LIMIT = 8'(TIMEOUT);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt_q + 8'd1;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = cnt_inc;
        end
    end

    // Expiry is flagged on the cycle that would bring the count up to LIMIT.
    assign expired_o = inc_i && !clr_i && (cnt_inc == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the memory req/ack read and feeds the IR.
// Handshake: mem_req rises with mem_addr and holds both stable until the cycle mem_ack=1.
module fetch_unit
    import xiphos_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = 16'h0000,
    parameter logic [WORD_W-1:0] PC_STEP  = 16'd1,
    parameter int unsigned       TIMEOUT  = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              mem_req,
    output logic [WORD_W-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [WORD_W-1:0] mem_rdata,
    output logic [WORD_W-1:0] ir_in,
    output logic              ir_ld,
    input  logic              ir_taken,
    input  logic              branch_valid,
    input  logic [WORD_W-1:0] branch_target,
    output logic [WORD_W-1:0] pc,
    output logic              fault,
    output fetch_state_t      dbg_state_o
);

    fetch_state_t      state_q, state_d;
    logic [WORD_W-1:0] pc_q, pc_d;
    logic [WORD_W-1:0] addr_q, addr_d;
    logic [WORD_W-1:0] ir_q, ir_d;
    logic              squash_q, squash_d;
    logic              fault_q, fault_d;
    logic              launch;
    logic              tmo_expired;

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr_i     ((state_q != REQ) || mem_ack),
        .inc_i     ((state_q == REQ) && !mem_ack),
        .expired_o (tmo_expired)
    );

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        addr_d   = addr_q;
        ir_d     = ir_q;
        squash_d = squash_q;
        fault_d  = fault_q;
        launch   = 1'b0;

        // A redirect always lands in the PC unless the unit is dead.
        if (branch_valid && (state_q != FAULT)) begin
            pc_d = branch_target;
        end

        case (state_q)
            IDLE: begin
                if (en) launch = 1'b1;
            end
            REQ: begin
                if (mem_ack) begin
                    if (squash_q || branch_valid) begin
                        squash_d = 1'b0;
                        launch   = 1'b1;
                    end else begin
                        ir_d    = mem_rdata;
                        pc_d    = pc_q + PC_STEP;
                        state_d = LOAD;
                    end
                end else if (tmo_expired) begin
                    fault_d  = 1'b1;
                    squash_d = 1'b0;
                    state_d  = FAULT;
                end else if (branch_valid) begin
                    squash_d = 1'b1;
                end
            end
            // LOAD doubles as the first HOLD cycle so a word acked on cycle N
            // can be followed by a new request on cycle N+2.
            LOAD, HOLD: begin
                if (en && (ir_taken || branch_valid)) begin
                    launch = 1'b1;
                end else if (ir_taken) begin
                    state_d = IDLE;
                end else begin
                    state_d = HOLD;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Every new transaction latches its address once and keeps it until ack.
        if (launch) begin
            state_d = REQ;
            addr_d  = pc_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            addr_q   <= RESET_PC;
            ir_q     <= '0;
            squash_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            addr_q   <= addr_d;
            ir_q     <= ir_d;
            squash_q <= squash_d;
            fault_q  <= fault_d;
        end
    end

    assign mem_req     = (state_q == REQ);
    assign mem_addr    = addr_q;
    assign ir_in       = ir_q;
    assign ir_ld       = (state_q == LOAD);
    assign pc          = pc_q;
    assign fault       = fault_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random traffic against a transaction-level model.
module tb_fetch_unit;
    import xiphos_pkg::*;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [15:0] PC_STEP  = 16'd1;
    localparam int          TIMEOUT  = 15;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en = 1'b0;
    logic         mem_req;
    logic [15:0]  mem_addr;
    logic         mem_ack = 1'b0;
    logic [15:0]  mem_rdata = '0;
    logic [15:0]  ir_in;
    logic         ir_ld;
    logic         ir_taken = 1'b0;
    logic         branch_valid = 1'b0;
    logic [15:0]  branch_target = '0;
    logic [15:0]  pc;
    logic         fault;
    fetch_state_t dbg_state;

    fetch_unit #(
        .RESET_PC (RESET_PC),
        .PC_STEP  (PC_STEP),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .ir_in         (ir_in),
        .ir_ld         (ir_ld),
        .ir_taken      (ir_taken),
        .branch_valid  (branch_valid),
        .branch_target (branch_target),
        .pc            (pc),
        .fault         (fault),
        .dbg_state_o   (dbg_state)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic mon_on = 1'b0;

    // Scoreboard: words the IR must receive, in order.
    logic [15:0] exp_q[$];

    // Reference model of the fetch unit's observable behaviour.
    logic        m_req, m_ld, m_hold, m_fault, m_squash;
    logic [15:0] m_pc, m_addr;
    int          m_wait;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_req = 1'b0; m_ld = 1'b0; m_hold = 1'b0; m_fault = 1'b0; m_squash = 1'b0;
        m_pc = RESET_PC; m_addr = RESET_PC; m_wait = 0;
        exp_q.delete();
    endtask

    task automatic model_launch();
        m_req  = 1'b1;
        m_addr = m_pc;
        m_wait = 0;
    endtask

    // Applies one rising edge to the model using the inputs that were present at it.
    task automatic model_edge();
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_fault) return;
        if (m_req) begin
            if (mem_ack) begin
                if (branch_valid) begin
                    m_pc = branch_target;
                    m_squash = 1'b0;
                    model_launch();
                end else if (m_squash) begin
                    m_squash = 1'b0;
                    model_launch();
                end else begin
                    exp_q.push_back(mem_rdata);
                    m_pc  = m_pc + PC_STEP;
                    m_req = 1'b0;
                    m_ld  = 1'b1;
                end
            end else begin
                if (branch_valid) begin
                    m_pc = branch_target;
                    m_squash = 1'b1;
                end
                m_wait++;
                if (m_wait == TIMEOUT) begin
                    m_fault = 1'b1;
                    m_req = 1'b0;
                end
            end
        end else if (m_ld || m_hold) begin
            if (branch_valid) m_pc = branch_target;
            m_ld = 1'b0;
            if (en && (ir_taken || branch_valid)) begin
                m_hold = 1'b0;
                model_launch();
            end else if (ir_taken) begin
                m_hold = 1'b0;
            end else begin
                m_hold = 1'b1;
            end
        end else begin
            if (branch_valid) m_pc = branch_target;
            if (en) model_launch();
        end
    endtask

    task automatic tick();
        @(negedge clk);
        model_edge();
    endtask

    task automatic set_in(input logic e, input logic a, input logic [15:0] d,
                          input logic t, input logic b, input logic [15:0] g);
        en = e; mem_ack = a; mem_rdata = d; ir_taken = t; branch_valid = b; branch_target = g;
    endtask

    task automatic ack_after(input int lat, input logic [15:0] d);
        for (int i = 0; i < lat; i++) begin
            mem_ack = 1'b0;
            tick();
        end
        mem_ack = 1'b1;
        mem_rdata = d;
        tick();
        mem_ack = 1'b0;
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_mem_req", 16'(mem_req), 16'h0);
        chk("async_pc", pc, RESET_PC);
        chk("async_ir_ld", 16'(ir_ld), 16'h0);
        chk("async_fault", 16'(fault), 16'h0);
        model_reset();
        @(negedge clk);
        model_edge();
        set_in(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        rst_n = 1'b1;
    endtask

    // Monitor: compares DUT outputs against the model mid-cycle, popping IR words on each load.
    initial begin
        logic [15:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_on) begin
                chk("mem_req", 16'(mem_req), 16'(m_req));
                if (m_req) chk("mem_addr", mem_addr, m_addr);
                chk("ir_ld", 16'(ir_ld), 16'(m_ld));
                chk("pc", pc, m_pc);
                chk("fault", 16'(fault), 16'(m_fault));
                if (ir_ld) begin
                    if (exp_q.size() == 0) begin
                        chk("ir_ld_unexpected", 16'(ir_ld), 16'h0);
                    end else begin
                        e = exp_q.pop_front();
                        chk("ir_in", ir_in, e);
                    end
                end else if (m_ld && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                end
            end
        end
    end

    initial begin
        int lat_left;
        model_reset();
        #12;
        chk("rst_mem_req", 16'(mem_req), 16'h0);
        chk("rst_ir_ld", 16'(ir_ld), 16'h0);
        chk("rst_ir_in", ir_in, 16'h0);
        chk("rst_pc", pc, RESET_PC);
        chk("rst_fault", 16'(fault), 16'h0);
        chk("rst_state", 16'(dbg_state), 16'(IDLE));
        @(negedge clk);
        rst_n = 1'b1;
        mon_on = 1'b1;

        // First fetch, ack one cycle after request.
        set_in(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        tick();
        ack_after(0, 16'hA5A5);
        en = 1'b0;
        tick();
        ir_taken = 1'b1;
        tick();
        ir_taken = 1'b0;

        // Ack delayed five cycles, then back-to-back refetch.
        en = 1'b1;
        tick();
        ack_after(5, 16'h1234);
        ir_taken = 1'b1;
        tick();
        ir_taken = 1'b0;

        // Branch two cycles into an unacked request squashes the returning word.
        tick();
        tick();
        set_in(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0040);
        tick();
        branch_valid = 1'b0;
        ack_after(1, 16'h1111);
        ack_after(0, 16'h2222);
        ir_taken = 1'b1;
        tick();
        ir_taken = 1'b0;

        // Branch and ack together, then fetch across the PC wrap.
        set_in(1'b1, 1'b1, 16'h3333, 1'b0, 1'b1, 16'hFFFF);
        tick();
        set_in(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        ack_after(2, 16'h4444);
        ir_taken = 1'b1;
        tick();
        ir_taken = 1'b0;
        ack_after(0, 16'h5555);
        set_in(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 16'h0100);
        tick();
        branch_valid = 1'b0;
        ack_after(1, 16'h6666);

        // Random traffic.
        lat_left = 0;
        for (int c = 0; c < 1200; c++) begin
            en = ($urandom_range(0, 9) != 0);
            ir_taken = ($urandom_range(0, 2) == 0);
            branch_valid = ($urandom_range(0, 14) == 0);
            branch_target = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(16'hFFFC, 16'hFFFF))
                                                        : 16'($urandom);
            mem_ack = 1'b0;
            mem_rdata = 16'($urandom);
            if (m_req) begin
                if (lat_left == 0) begin
                    mem_ack = 1'b1;
                    lat_left = $urandom_range(0, 6);
                end else begin
                    lat_left--;
                end
            end
            tick();
        end

        // Asynchronous reset while a request is outstanding.
        set_in(1'b1, 1'b0, 16'h0, 1'b1, 1'b0, 16'h0);
        for (int i = 0; i < 10 && !m_req; i++) tick();
        tick();
        pulse_reset();

        // Never ack: timeout fault, then a branch that must be ignored.
        set_in(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 25; i++) begin
            ir_taken = i[0];
            branch_valid = (i == 20);
            branch_target = 16'h0777;
            tick();
        end
        pulse_reset();
        tick();
        tick();

        mon_on = 1'b0;
        chk("exp_q_drained", 16'(exp_q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
